gpio_cfg_reg_bank: RTL
======================

// Module: gpio_cfg_reg_bank
// PURPOSE
// - Parametrised host-to-fabric config register bank on the PS GPIO bus; replaces per-block ad hoc GPIO decoding.
// - Sync write-clock bit, edge-detect, latch addr/data fields, byte-shift data into NUM_REGS x REG_W registers.
// - Low addresses are trigger addresses: they emit 1-cycle pulses instead of storing data.
// - Feeds drivers, DAC muxes and the executor with flat register outputs; toggles an ack bit per committed write.
// PARAMETERS
// - GPIO_W       32  width of gpio_in
// - W_CLK_BIT    24  gpio_in bit used as host write clock
// - ADDR_LSB     0   addr field LSB; field is [ADDR_LSB+ADDR_W-1:ADDR_LSB]
// - ADDR_W       16  addr field width
// - DATA_LSB     16  data field LSB; field is [DATA_LSB+DATA_W-1:DATA_LSB]
// - DATA_W       8   data field width
// - NUM_REGS     64  storage registers, at addresses 0..NUM_REGS-1
// - REG_W        32  register width; multiple of DATA_W, >= DATA_W
// - NUM_TRIG     3   addresses 0..NUM_TRIG-1 are pulse-only (run/del/halt)
// - SYNC_STAGES  2   synchroniser depth on gpio_in, >= 2
// - RD_SEL_ADDR  16'h00FF  readback select address; only used when REG_READBACK_EN
// PORTS
// - clk          in   1               fabric clock
// - rst          in   1               async, active-low reset
// - gpio_in      in   GPIO_W          raw PS GPIO word (asynchronous to clk)
// - regs_flat    out  NUM_REGS*REG_W  register i at [i*REG_W +: REG_W]
// - trig_pulse   out  NUM_TRIG        1-cycle pulse per trigger write
// - wr_stb       out  1               1-cycle pulse on each stored write
// - wr_addr      out  ADDR_W          address of the last committed write
// - gpio_ack     out  1               toggles on every committed transaction
// - bad_addr_cnt out  8               saturating count of out-of-range writes
// - rd_data      out  REG_W           readback word (REG_READBACK_EN only; else 0)
// BEHAVIOUR
// - Reset (rst=0, async): all regs, outputs, counters and synchroniser flops = 0; FSM = IDLE.
// - Whole gpio_in word passes through SYNC_STAGES flops. The sync'd W_CLK_BIT gets one more flop for edge detect.
// - FSM IDLE: on a rising edge of the sync'd w_clk, latch addr/data -> COMMIT.
// - FSM COMMIT (1 cycle), by latched address:
//   - a < NUM_TRIG: trig_pulse[a] = 1.
//   - NUM_TRIG <= a < NUM_REGS: reg[a] <= {reg[a][REG_W-DATA_W-1:0], data}; wr_stb = 1.
//   - a == RD_SEL_ADDR (macro on): rd_ptr <= data.
//   - any other a: bad_addr_cnt++ (saturates at 255); no other effect.
//   - In every case: gpio_ack toggles, wr_addr <= a; -> WAIT_LOW.
// - FSM WAIT_LOW: stay until sync'd w_clk = 0 -> IDLE. A held-high w_clk commits exactly once.
// - Latency: gpio_in edge to regs/trig/ack update = SYNC_STAGES+2 clk.
// - Host must hold addr/data stable from before the w_clk rise until ack toggles.
// - When REG_W == DATA_W, the shift reduces to a plain overwrite.
// - Trigger addresses hold no storage; their slots in regs_flat read 0.
// - Async reset mid-transaction discards it: no pulse, no ack toggle.
// CONFIGURATION
// - REG_READBACK_EN defined:
//   - rd_ptr (8 b) is selected by writes to RD_SEL_ADDR.
//   - rd_data = regs[rd_ptr], registered, updated every cycle.
//   - rd_ptr >= NUM_REGS gives rd_data = 0.
// - REG_READBACK_EN undefined: no rd_ptr; rd_data tied 0; RD_SEL_ADDR counts as a bad address.
// STRUCTURE
// - Shared package (ising_config): GPIO field positions/widths, trigger address constants,
//   state enum typedef {IDLE, COMMIT, WAIT_LOW}, RD_SEL_ADDR.
// - One sub-module: gpio_bus_sync (parametrised multi-bit synchroniser plus rising-edge detect on W_CLK_BIT).
// TESTING
// - Write 0x12,0x34,0x56,0x78 to addr 0x000C -> reg[12]=0x12345678; 4 wr_stb; gpio_ack ends at start value.
// - Write addr 0x0000 data 0xFF -> trig_pulse=3'b001 for exactly 1 clk; regs unchanged; no wr_stb.
// - Hold w_clk high 50 cycles -> exactly one commit; the next rise after a low commits again.
// - Write addr 0x1234 (>=NUM_REGS) 300 times -> bad_addr_cnt=255; regs unchanged; ack toggled 300 times.
// - Deassert rst for 1 cycle during COMMIT of a write to addr 5 -> all regs 0, no trig, state IDLE.
// - REG_READBACK_EN: reg[20]=0xA5; write RD_SEL_ADDR data 20 -> rd_data=0x000000A5 next clk.

Source files
------------

// File: rtl/ising_config.sv
// Shared constants for the GPIO configuration register bank: bus field layout,
// trigger addresses, readback select address and the commit FSM state type.
package ising_config;

  localparam int CFG_GPIO_W      = 32;
  localparam int CFG_W_CLK_BIT   = 24;
  localparam int CFG_ADDR_LSB    = 0;
  localparam int CFG_ADDR_W      = 16;
  localparam int CFG_DATA_LSB    = 16;
  localparam int CFG_DATA_W      = 8;
  localparam int CFG_NUM_REGS    = 64;
  localparam int CFG_REG_W       = 32;
  localparam int CFG_NUM_TRIG    = 3;
  localparam int CFG_SYNC_STAGES = 2;

  localparam logic [CFG_ADDR_W-1:0] CFG_RD_SEL_ADDR = 16'h00FF;

  // Trigger addresses: writes here pulse trig_pulse[n] instead of storing data.
  localparam logic [CFG_ADDR_W-1:0] TRIG_RUN  = 16'h0000;
  localparam logic [CFG_ADDR_W-1:0] TRIG_DEL  = 16'h0001;
  localparam logic [CFG_ADDR_W-1:0] TRIG_HALT = 16'h0002;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    WAIT_LOW = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/gpio_bus_sync.sv
// Multi-bit synchroniser for the asynchronous PS GPIO word, plus a rising-edge
// detector on the bit the host uses as its write clock.
module gpio_bus_sync #(
  parameter int W        = 32,
  parameter int STAGES   = 2,
  parameter int EDGE_BIT = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         level_o,
  output logic         rise_o
);

  logic [W-1:0] sync_q [STAGES];
  logic         edge_q;

  // NOTE: non-blocking assignments make every stage sample its predecessor's
  // previous value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q <= sync_q[STAGES-1][EDGE_BIT];
    end
  end

  assign q_o     = sync_q[STAGES-1];
  assign level_o = sync_q[STAGES-1][EDGE_BIT];
  assign rise_o  = sync_q[STAGES-1][EDGE_BIT] & ~edge_q;

endmodule

// File: rtl/gpio_cfg_reg_bank.sv
// Host-to-fabric configuration register bank driven over the PS GPIO bus.
// Optional readback path enabled by defining REG_READBACK_EN.
module gpio_cfg_reg_bank
  import ising_config::*;
#(
  parameter int GPIO_W      = CFG_GPIO_W,
  parameter int W_CLK_BIT   = CFG_W_CLK_BIT,
  parameter int ADDR_LSB    = CFG_ADDR_LSB,
  parameter int ADDR_W      = CFG_ADDR_W,
  parameter int DATA_LSB    = CFG_DATA_LSB,
  parameter int DATA_W      = CFG_DATA_W,
  parameter int NUM_REGS    = CFG_NUM_REGS,
  parameter int REG_W       = CFG_REG_W,
  parameter int NUM_TRIG    = CFG_NUM_TRIG,
  parameter int SYNC_STAGES = CFG_SYNC_STAGES,
  parameter logic [ADDR_W-1:0] RD_SEL_ADDR = ADDR_W'(CFG_RD_SEL_ADDR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GPIO_W-1:0]         gpio_in,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic [NUM_TRIG-1:0]       trig_pulse,
  output logic                      wr_stb,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      gpio_ack,
  output logic [7:0]                bad_addr_cnt,
  output logic [REG_W-1:0]          rd_data
);

`ifdef REG_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic [GPIO_W-1:0] gpio_s;
  logic              wclk_lvl;
  logic              wclk_rise;
  logic              gpio_unused;

  gpio_bus_sync #(
    .W        (GPIO_W),
    .STAGES   (SYNC_STAGES),
    .EDGE_BIT (W_CLK_BIT)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (gpio_in),
    .q_o     (gpio_s),
    .level_o (wclk_lvl),
    .rise_o  (wclk_rise)
  );

  // Bits outside the addr/data fields are synchronised but carry no meaning here.
  assign gpio_unused = ^gpio_s;

  cfg_state_e        state_q, state_d;
  logic              commit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE:     if (wclk_rise) state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: if (!wclk_lvl) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (state_q == IDLE && wclk_rise) begin
      addr_q <= gpio_s[ADDR_LSB +: ADDR_W];
      data_q <= gpio_s[DATA_LSB +: DATA_W];
    end
  end

  logic is_trig, is_reg, is_rdsel, is_bad;

  assign is_trig  = addr_q < ADDR_W'(NUM_TRIG);
  assign is_reg   = !is_trig && (addr_q < ADDR_W'(NUM_REGS));
  assign is_rdsel = RB_EN && !is_trig && !is_reg && (addr_q == RD_SEL_ADDR);
  assign is_bad   = !is_trig && !is_reg && !is_rdsel;

  logic [NUM_TRIG-1:0] trig_d;

  always_comb begin
    trig_d = '0;
    for (int t = 0; t < NUM_TRIG; t++)
      trig_d[t] = commit && is_trig && (addr_q == ADDR_W'(t));
  end

  logic [NUM_TRIG-1:0] trig_q;
  logic                stb_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                ack_q;
  logic [7:0]          bad_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q    <= '0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      ack_q     <= 1'b0;
      bad_q     <= '0;
    end else begin
      trig_q <= trig_d;
      stb_q  <= commit && is_reg;
      if (commit) begin
        ack_q     <= ~ack_q;
        wr_addr_q <= addr_q;
        if (is_bad && bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
      end
    end
  end

  assign trig_pulse   = trig_q;
  assign wr_stb       = stb_q;
  assign wr_addr      = wr_addr_q;
  assign gpio_ack     = ack_q;
  assign bad_addr_cnt = bad_q;

  // Shifting left by DATA_W degenerates to a plain overwrite when REG_W == DATA_W.
  logic [REG_W-1:0] data_ext;
  assign data_ext = REG_W'(data_q);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i < NUM_TRIG) begin : g_trig_slot
      assign regs_flat[i*REG_W +: REG_W] = '0;
    end else begin : g_store
      logic [REG_W-1:0] reg_q;
      // NOTE: the bank is built from flops rather than a RAM, so it is reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          reg_q <= '0;
        else if (commit && is_reg && addr_q == ADDR_W'(i))
          reg_q <= (reg_q << DATA_W) | data_ext;
      end
      assign regs_flat[i*REG_W +: REG_W] = reg_q;
    end
  end

`ifdef REG_READBACK_EN
  logic [7:0]       rd_ptr_q;
  logic [REG_W-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (commit && is_rdsel) rd_ptr_q <= 8'(data_q);
      if (int'(rd_ptr_q) < NUM_REGS)
        rd_data_q <= regs_flat[int'(rd_ptr_q)*REG_W +: REG_W];
      else
        rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;
`else
  assign rd_data = '0;
`endif

endmodule
